// File: rtl/seg7_reader.sv
// seg7_reader: recovers per-digit BCD values from a multiplexed active-low
// 7-segment bus, committing a digit only after STABLE identical samples.

module seg7_slot (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [3:0] wval,
   output logic [3:0] val,
   output logic       valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val   <= 4'hF;
         valid <= 1'b0;
      end else if (we) begin
         val   <= wval;
         valid <= (wval != 4'hF);
      end
   end

endmodule

module seg7_reader #(
   parameter int NDIG   = 8,
   parameter int STABLE = 3
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              sample_en,
   input  logic [0:6]        seg_in,
   input  logic [NDIG-1:0]   dig_sel,
   input  logic              err_clr,
   output logic [4*NDIG-1:0] bcd_out,
   output logic [NDIG-1:0]   digit_valid,
   output logic              update,
   output logic              err,
   output logic              err_sticky,
   output logic [3:0]        err_digit,
   output logic              sel_err
);

   localparam logic [3:0] STB = 4'(STABLE);

   typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

   typedef struct packed {
      logic [NDIG-1:0] sel;
      logic [6:0]      seg;
   } samp_t;

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   samp_t      cand, cand_nx, cur;
   logic       onehot, commit, sel_bad, load;
   logic [3:0] sel_idx;
   logic [4:0] dec;
   logic       dec_bad;
   logic [3:0] dec_val;
   logic [NDIG-1:0] slot_we;

   // {illegal, value}; blank decodes to value F with illegal clear
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'b0000001: decode = 5'h00;
         7'b1001111: decode = 5'h01;
         7'b0010010: decode = 5'h02;
         7'b0000110: decode = 5'h03;
         7'b1001100: decode = 5'h04;
         7'b0100100: decode = 5'h05;
         7'b0100000: decode = 5'h06;
         7'b0001111: decode = 5'h07;
         7'b0000000: decode = 5'h08;
         7'b0000100: decode = 5'h09;
         7'b1111111: decode = 5'h0F;
         default:    decode = 5'h1F;
      endcase
   endfunction

   assign cur     = '{sel: dig_sel, seg: seg_in};
   assign onehot  = $onehot(dig_sel);
   assign dec     = decode(seg_in);
   assign dec_bad = dec[4];
   assign dec_val = dec[3:0];

   always_comb begin
      sel_idx = 4'd0;
      for (int i = 0; i < NDIG; i++)
         if (dig_sel[i]) sel_idx = 4'(i);
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         cand  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         cand  <= cand_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cand_nx  = cand;
      commit   = 1'b0;
      sel_bad  = 1'b0;
      load     = 1'b0;
      if (sample_en) begin
         if (!onehot) begin
            sel_bad  = 1'b1;
            state_nx = IDLE;
            cnt_nx   = 4'd0;
         end else begin
            case (state)
               IDLE:  load = 1'b1;
               TRACK: begin
                  if (cur == cand) begin
                     cnt_nx = cnt + 4'd1;
                     if (cnt + 4'd1 == STB) begin
                        commit   = 1'b1;
                        state_nx = HELD;
                     end
                  end else begin
                     load = 1'b1;
                  end
               end
               HELD:  if (cur != cand) load = 1'b1;
               default: begin
                  state_nx = IDLE;
                  cnt_nx   = 4'd0;
               end
            endcase
            // a fresh candidate is already a full streak when STABLE is 1
            if (load) begin
               cand_nx = cur;
               cnt_nx  = 4'd1;
               if (STABLE == 1) begin
                  commit   = 1'b1;
                  state_nx = HELD;
               end else begin
                  state_nx = TRACK;
               end
            end
         end
      end
   end

   assign slot_we = (commit && !dec_bad) ? dig_sel : '0;

   for (genvar k = 0; k < NDIG; k++) begin : g_slot
      seg7_slot u_slot (
         .clk   (CLOCK_50),
         .rst   (reset),
         .we    (slot_we[k]),
         .wval  (dec_val),
         .val   (bcd_out[4*k +: 4]),
         .valid (digit_valid[k])
      );
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         update     <= 1'b0;
         err        <= 1'b0;
         sel_err    <= 1'b0;
         err_sticky <= 1'b0;
         err_digit  <= 4'd0;
      end else begin
         update  <= commit && !dec_bad;
         err     <= commit && dec_bad;
         sel_err <= sel_bad;
         if (commit && dec_bad) err_digit <= sel_idx;
         // a new error outranks a simultaneous clear
         if ((commit && dec_bad) || sel_bad) err_sticky <= 1'b1;
         else if (err_clr)                    err_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed scenarios then random scanning, checked
// against a streak-counting model of the display reader.

module tb_seg7_reader;

   localparam int NDIG   = 8;
   localparam int STABLE = 3;

   logic              CLOCK_50 = 1'b0;
   logic              reset = 1'b1;
   logic              sample_en = 1'b0;
   logic [0:6]        seg_in = 7'h7F;
   logic [NDIG-1:0]   dig_sel = '0;
   logic              err_clr = 1'b0;
   logic [4*NDIG-1:0] bcd_out;
   logic [NDIG-1:0]   digit_valid;
   logic              update, err, err_sticky, sel_err;
   logic [3:0]        err_digit;

   seg7_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .sample_en   (sample_en),
      .seg_in      (seg_in),
      .dig_sel     (dig_sel),
      .err_clr     (err_clr),
      .bcd_out     (bcd_out),
      .digit_valid (digit_valid),
      .update      (update),
      .err         (err),
      .err_sticky  (err_sticky),
      .err_digit   (err_digit),
      .sel_err     (sel_err)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int vecs = 0;
   int miss = 0;

   logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100};

   // model: a commit happens when the streak of identical qualified samples
   // reaches exactly STABLE
   logic [3:0]      m_slot [NDIG];
   logic            m_valid [NDIG];
   logic            m_upd, m_err, m_selerr, m_sticky;
   logic [3:0]      m_edig;
   logic [NDIG-1:0] l_sel;
   logic [6:0]      l_seg;
   int              run;

   task automatic model_reset();
      for (int i = 0; i < NDIG; i++) begin
         m_slot[i]  = 4'hF;
         m_valid[i] = 1'b0;
      end
      m_upd = 0; m_err = 0; m_selerr = 0; m_sticky = 0; m_edig = 0;
      run = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         miss++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic [4*NDIG-1:0] eb;
      logic [NDIG-1:0]   ev;
      for (int i = 0; i < NDIG; i++) begin
         eb[4*i +: 4] = m_slot[i];
         ev[i]        = m_valid[i];
      end
      chk("bcd_out", 32'(bcd_out), 32'(eb));
      chk("digit_valid", 32'(digit_valid), 32'(ev));
      chk("update", 32'(update), 32'(m_upd));
      chk("err", 32'(err), 32'(m_err));
      chk("sel_err", 32'(sel_err), 32'(m_selerr));
      chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
      chk("err_digit", 32'(err_digit), 32'(m_edig));
   endtask

   task automatic step(input logic en, input logic [NDIG-1:0] sel,
                       input logic [6:0] seg, input logic clr);
      int k, v;
      @(negedge CLOCK_50);
      sample_en = en; dig_sel = sel; seg_in = seg; err_clr = clr;
      @(posedge CLOCK_50);
      m_upd = 0; m_err = 0; m_selerr = 0;
      if (en) begin
         if ($countones(sel) != 1) begin
            m_selerr = 1;
            run = 0;
         end else begin
            if (run > 0 && sel == l_sel && seg == l_seg) begin
               if (run < 1000) run++;
            end else begin
               l_sel = sel; l_seg = seg; run = 1;
            end
            if (run == STABLE) begin
               k = 0;
               for (int i = 0; i < NDIG; i++) if (sel[i]) k = i;
               v = -1;
               for (int i = 0; i < 10; i++) if (pat[i] == seg) v = i;
               if (seg == 7'h7F) v = 15;
               if (v >= 0) begin
                  m_slot[k]  = 4'(v);
                  m_valid[k] = (v != 15);
                  m_upd      = 1;
               end else begin
                  m_err  = 1;
                  m_edig = 4'(k);
               end
            end
         end
      end
      if (m_err || m_selerr) m_sticky = 1;
      else if (clr)          m_sticky = 0;
      #1 check_all();
   endtask

   task automatic pulse_reset();
      @(negedge CLOCK_50);
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge CLOCK_50);
      #1 reset = 1'b0;
   endtask

   initial begin
      int hold;
      logic [NDIG-1:0] rsel;
      logic [6:0]      rseg;
      model_reset();
      repeat (3) @(posedge CLOCK_50);
      #1 check_all();
      chk("reset_bcd", bcd_out, 32'hFFFF_FFFF);
      @(negedge CLOCK_50) reset = 1'b0;
      step(0, '0, 7'h7F, 0);

      // digit 2 shows "2"
      repeat (3) step(1, 8'h04, 7'b0010010, 0);
      chk("dig2_val", 32'(bcd_out[11:8]), 32'd2);
      chk("dig2_upd", 32'(update), 32'd1);
      step(1, 8'h04, 7'b0010010, 0);
      chk("dig2_noupd", 32'(update), 32'd0);

      // flicker on digit 0 never commits
      for (int i = 0; i < 10; i++) step(1, 8'h01, (i % 2) ? 7'b1001111 : 7'b0000001, 0);
      repeat (3) step(1, 8'h01, 7'b0000001, 0);
      chk("dig0_val", 32'(bcd_out[3:0]), 32'd0);

      // illegal pattern on digit 7, then clear racing a select error
      repeat (3) step(1, 8'h80, 7'b1111110, 0);
      chk("dig7_errdig", 32'(err_digit), 32'd7);
      step(1, 8'h03, 7'b0000001, 1);
      chk("sticky_hold", 32'(err_sticky), 32'd1);
      step(0, 8'h00, 7'h7F, 1);
      chk("sticky_clr", 32'(err_sticky), 32'd0);

      // digit 5: 9 then blank
      repeat (3) step(1, 8'h20, 7'b0000100, 0);
      repeat (3) step(1, 8'h20, 7'b1111111, 0);
      chk("dig5_blank", 32'(bcd_out[23:20]), 32'hF);

      // reset mid-track discards the partial streak
      repeat (2) step(1, 8'h02, 7'b0001111, 0);
      pulse_reset();
      repeat (2) step(1, 8'h02, 7'b0001111, 0);
      chk("dig1_nocommit", 32'(digit_valid[1]), 32'd0);

      // random scanning with gaps, glitches and bad selects
      hold = 0;
      rsel = 8'h01;
      rseg = 7'h7F;
      for (int n = 0; n < 500; n++) begin
         if (hold == 0) begin
            if ($urandom_range(0, 9) == 0) rsel = NDIG'($urandom);
            else                           rsel = NDIG'(1) << $urandom_range(0, NDIG-1);
            case ($urandom_range(0, 9))
               0:       rseg = 7'($urandom);
               1:       rseg = 7'h7F;
               default: rseg = pat[$urandom_range(0, 9)];
            endcase
            hold = $urandom_range(1, 5);
         end
         step($urandom_range(0, 4) != 0, rsel, rseg, $urandom_range(0, 7) == 0);
         hold--;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
